// File: rtl/sram_ecc_pkg.sv
// sram_ecc_pkg: shared types and bit-position tables for the extended Hamming (39,32) SECDED code
package sram_ecc_pkg;
  localparam int CODE_WIDTH = 39;
  localparam int SYN_WIDTH = 6;
  typedef logic [CODE_WIDTH-1:0] code_t;
  typedef enum logic [1:0] {CLEAN, CORR, UNCORR} ecc_status_e;
  localparam int CHK_POS [SYN_WIDTH] = '{1, 2, 4, 8, 16, 32};
  localparam int DATA_POS [32] = '{3, 5, 6, 7, 9, 10, 11, 12, 13, 14, 15, 17, 18, 19, 20, 21,
                                   22, 23, 24, 25, 26, 27, 28, 29, 30, 31, 33, 34, 35, 36, 37, 38};
endpackage

// File: rtl/ecc_secded_codec.sv
// ecc_secded_codec: combinational SECDED encoder (32->39) and decoder (39->32 + status + syndrome)
module ecc_secded_codec
  import sram_ecc_pkg::*;
(
  input  logic [31:0]          enc_data_i,
  output code_t                enc_code_o,
  input  code_t                dec_code_i,
  output logic [31:0]          dec_data_o,
  output ecc_status_e          dec_status_o,
  output logic [SYN_WIDTH-1:0] dec_syn_o
);
  code_t enc, fix;
  logic [SYN_WIDTH-1:0] syn;
  logic par;
  always_comb begin
    enc = '0;
    for (int i = 0; i < 32; i++) enc[DATA_POS[i]] = enc_data_i[i];
    for (int k = 0; k < SYN_WIDTH; k++)
      for (int j = 1; j < CODE_WIDTH; j++)
        if ((j & CHK_POS[k]) != 0 && j != CHK_POS[k]) enc[CHK_POS[k]] = enc[CHK_POS[k]] ^ enc[j];
    enc[0] = ^enc[CODE_WIDTH-1:1];
    enc_code_o = enc;
  end
  // A set overall parity means an odd error count; the syndrome names the bit (0 = parity bit).
  always_comb begin
    syn = '0;
    for (int k = 0; k < SYN_WIDTH; k++)
      for (int j = 1; j < CODE_WIDTH; j++)
        if ((j & CHK_POS[k]) != 0) syn[k] = syn[k] ^ dec_code_i[j];
    par = ^dec_code_i;
    fix = dec_code_i ^ (par ? (code_t'(1) << syn) : '0);
    for (int i = 0; i < 32; i++) dec_data_o[i] = fix[DATA_POS[i]];
    dec_status_o = par ? CORR : (syn != '0 ? UNCORR : CLEAN);
    dec_syn_o = syn;
  end
endmodule

// File: rtl/sram_ecc_wrapper.sv
// sram_ecc_wrapper: SECDED-protected word SRAM, 1-cycle read latency, error pulses/counters/address.
// Defining ECC_SCRUB_EN adds a single-slot write-back of corrected words during idle cycles.
module sram_ecc_wrapper
  import sram_ecc_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int NUM_WORDS  = 1024,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    req_i,
  input  logic                    we_i,
  input  logic [ADDR_WIDTH-1:0]   addr_i,
  input  logic [DATA_WIDTH/8-1:0] be_i,
  input  logic [DATA_WIDTH-1:0]   data_i,
  output logic [DATA_WIDTH-1:0]   data_o,
  input  logic [CODE_WIDTH-1:0]   inj_flip_i,
  output logic                    err_corr_o,
  output logic                    err_uncorr_o,
  output logic                    be_err_o,
  output logic [ADDR_WIDTH-1:0]   err_addr_o,
  output logic [CNT_WIDTH-1:0]    corr_cnt_o,
  output logic [CNT_WIDTH-1:0]    uncorr_cnt_o,
  input  logic                    clr_cnt_i
);
  localparam int IW = $clog2(NUM_WORDS);
  code_t mem [NUM_WORDS];
  code_t wr_code, fix_code, rd_code_q, rd_code_d;
  logic rd_vld_q, rd_vld_d, be_err_q, be_err_d;
  logic [ADDR_WIDTH-1:0] rd_addr_q, rd_addr_d, err_addr_q, err_addr_d;
  logic [CNT_WIDTH-1:0] corr_cnt_q, corr_cnt_d, uncorr_cnt_q, uncorr_cnt_d;
  logic [IW-1:0] idx, rd_idx;
  logic [DATA_WIDTH-1:0] rd_data;
  ecc_status_e rd_status, unused_wr_status;
  logic [31:0] unused_wr_data;
  logic [SYN_WIDTH-1:0] unused_wr_syn, unused_rd_syn;
  logic wr_en, rd_en, corr_ev, uncorr_ev, scrub_hit, scrub_wb;
  logic [IW-1:0] scrub_idx_q;
  code_t scrub_code_q;
  assign idx = addr_i[IW+1:2];
  assign rd_idx = rd_addr_q[IW+1:2];
  assign wr_en = req_i & we_i & (&be_i);
  assign rd_en = req_i & ~we_i;
  assign corr_ev = rd_vld_q & (rd_status == CORR);
  assign uncorr_ev = rd_vld_q & (rd_status == UNCORR);
  ecc_secded_codec u_wr (
    .enc_data_i(data_i), .enc_code_o(wr_code), .dec_code_i('0),
    .dec_data_o(unused_wr_data), .dec_status_o(unused_wr_status), .dec_syn_o(unused_wr_syn)
  );
  // Re-encoding the corrected read data yields the clean codeword used for scrubbing.
  ecc_secded_codec u_rd (
    .enc_data_i(rd_data), .enc_code_o(fix_code), .dec_code_i(rd_code_q),
    .dec_data_o(rd_data), .dec_status_o(rd_status), .dec_syn_o(unused_rd_syn)
  );
`ifdef ECC_SCRUB_EN
  logic scrub_vld_q, scrub_vld_d;
  logic [IW-1:0] scrub_idx_d;
  code_t scrub_code_d;
  assign scrub_hit = scrub_vld_q & (scrub_idx_q == idx);
  assign scrub_wb = scrub_vld_q & ~req_i;
  always_comb begin
    scrub_vld_d = scrub_vld_q & req_i & ~(wr_en & (scrub_idx_q == idx));
    scrub_idx_d = scrub_idx_q;
    scrub_code_d = scrub_code_q;
    if (corr_ev && !(wr_en && idx == rd_idx)) begin
      scrub_vld_d = 1'b1;
      scrub_idx_d = rd_idx;
      scrub_code_d = fix_code;
    end
  end
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) begin
      scrub_vld_q <= 1'b0;
      scrub_idx_q <= '0;
      scrub_code_q <= '0;
    end else begin
      scrub_vld_q <= scrub_vld_d;
      scrub_idx_q <= scrub_idx_d;
      scrub_code_q <= scrub_code_d;
    end
`else
  logic unused_fix;
  assign unused_fix = ^fix_code;
  assign scrub_hit = 1'b0;
  assign scrub_wb = 1'b0;
  assign scrub_idx_q = '0;
  assign scrub_code_q = '0;
`endif
  always_ff @(posedge clk_i)
    if (wr_en) mem[idx] <= wr_code ^ inj_flip_i;
    else if (scrub_wb) mem[scrub_idx_q] <= scrub_code_q;
  always_comb begin
    rd_vld_d = rd_en;
    rd_code_d = rd_en ? (scrub_hit ? scrub_code_q : mem[idx]) : rd_code_q;
    rd_addr_d = rd_en ? addr_i : rd_addr_q;
    be_err_d = req_i & we_i & ~(&be_i);
    err_addr_d = (corr_ev | uncorr_ev) ? rd_addr_q : err_addr_q;
    corr_cnt_d = clr_cnt_i ? '0 : corr_cnt_q + CNT_WIDTH'(corr_ev & ~(&corr_cnt_q));
    uncorr_cnt_d = clr_cnt_i ? '0 : uncorr_cnt_q + CNT_WIDTH'(uncorr_ev & ~(&uncorr_cnt_q));
  end
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) begin
      rd_vld_q <= 1'b0;
      rd_code_q <= '0;
      rd_addr_q <= '0;
      be_err_q <= 1'b0;
      err_addr_q <= '0;
      corr_cnt_q <= '0;
      uncorr_cnt_q <= '0;
    end else begin
      rd_vld_q <= rd_vld_d;
      rd_code_q <= rd_code_d;
      rd_addr_q <= rd_addr_d;
      be_err_q <= be_err_d;
      err_addr_q <= err_addr_d;
      corr_cnt_q <= corr_cnt_d;
      uncorr_cnt_q <= uncorr_cnt_d;
    end
  assign data_o = rd_data;
  assign err_corr_o = corr_ev;
  assign err_uncorr_o = uncorr_ev;
  assign be_err_o = be_err_q;
  assign err_addr_o = err_addr_q;
  assign corr_cnt_o = corr_cnt_q;
  assign uncorr_cnt_o = uncorr_cnt_q;
endmodule

// File: tb/tb_sram_ecc_wrapper.sv
// tb_sram_ecc_wrapper: directed and randomized checks of sram_ecc_wrapper against a flip-mask memory model
module tb_sram_ecc_wrapper;
  logic clk = 0, rst = 1, req = 0, we = 0, clr = 0;
  logic [31:0] addr = 0, din = 0, dout, err_addr;
  logic [3:0] be = 4'hF, corr_cnt, uncorr_cnt;
  logic [38:0] inj = 0;
  logic err_corr, err_uncorr, be_err;
  int total = 0, passed = 0;
  logic [31:0] m_data [8];
  logic [38:0] m_flip [8];
  int mc, mu;
  logic [31:0] mea;

  sram_ecc_wrapper #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .NUM_WORDS(1024), .CNT_WIDTH(4)) dut (
    .clk_i(clk), .rst_i(rst), .req_i(req), .we_i(we), .addr_i(addr), .be_i(be), .data_i(din),
    .data_o(dout), .inj_flip_i(inj), .err_corr_o(err_corr), .err_uncorr_o(err_uncorr),
    .be_err_o(be_err), .err_addr_o(err_addr), .corr_cnt_o(corr_cnt), .uncorr_cnt_o(uncorr_cnt),
    .clr_cnt_i(clr)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] b, input logic [38:0] f);
    req = 1; we = 1; addr = a; din = d; be = b; inj = f;
    cyc();
    req = 0; we = 0; be = 4'hF; inj = 0;
  endtask

  task automatic rd(input logic [31:0] a);
    req = 1; we = 0; addr = a;
    cyc();
    req = 0;
  endtask

  // Data bit i lives at the i-th non-power-of-two position in 1..38.
  function automatic logic [31:0] flip_data(input logic [31:0] d, input logic [38:0] f);
    int n;
    logic [31:0] r;
    n = 0;
    r = d;
    for (int p = 3; p < 39; p++)
      if ((p & (p - 1)) != 0) begin
        r[n] = r[n] ^ f[p];
        n++;
      end
    return r;
  endfunction

  initial begin
    int k, pc, p1, p2;
    logic [31:0] a, d, ed;
    logic [38:0] f;
    logic [3:0] b;
    cyc(); cyc();
    chk("rst_data", dout, 0);
    chk("rst_corr", err_corr, 0);
    chk("rst_uncorr", err_uncorr, 0);
    chk("rst_be_err", be_err, 0);
    chk("rst_err_addr", err_addr, 0);
    chk("rst_corr_cnt", corr_cnt, 0);
    chk("rst_uncorr_cnt", uncorr_cnt, 0);
    rst = 0;
    cyc();
    wr(32'h10, 32'hDEADBEEF, 4'hF, 0);
    chk("full_wr_be_err", be_err, 0);
    rd(32'h10);
    chk("clean_data", dout, 32'hDEADBEEF);
    chk("clean_corr", err_corr, 0);
    chk("clean_uncorr", err_uncorr, 0);
    cyc();
    chk("clean_corr_cnt", corr_cnt, 0);
    chk("clean_uncorr_cnt", uncorr_cnt, 0);
    chk("hold_data", dout, 32'hDEADBEEF);
    wr(32'h20, 32'h12345678, 4'hF, 39'h1 << 5);
    rd(32'h20);
    chk("sbe_data", dout, 32'h12345678);
    chk("sbe_corr", err_corr, 1);
    chk("sbe_uncorr", err_uncorr, 0);
    cyc();
    chk("sbe_pulse_len", err_corr, 0);
    chk("sbe_corr_cnt", corr_cnt, 1);
    chk("sbe_err_addr", err_addr, 32'h20);
    cyc();
    wr(32'h30, 32'hA5A5A5A5, 4'hF, (39'h1 << 3) | (39'h1 << 9));
    rd(32'h30);
    chk("dbe_data", dout, 32'hA5A5A5B4);
    chk("dbe_uncorr", err_uncorr, 1);
    chk("dbe_corr", err_corr, 0);
    cyc();
    chk("dbe_uncorr_cnt", uncorr_cnt, 1);
    chk("dbe_err_addr", err_addr, 32'h30);
    wr(32'h40, 32'h55AA55AA, 4'hF, 0);
    wr(32'h40, 32'h0, 4'h3, 0);
    chk("part_be_err", be_err, 1);
    cyc();
    chk("part_be_err_len", be_err, 0);
    rd(32'h40);
    chk("part_keep", dout, 32'h55AA55AA);
    cyc();
    wr(32'h20, 32'h12345678, 4'hF, 39'h1 << 5);
    req = 1; we = 0; addr = 32'h20;
    cyc();
    chk("b2b_corr1", err_corr, 1);
    cyc();
    req = 0; clr = 1;
    chk("b2b_corr2", err_corr, 1);
    cyc();
    clr = 0;
    chk("clr_corr_cnt", corr_cnt, 0);
    chk("clr_uncorr_cnt", uncorr_cnt, 0);
    cyc();
    rd(32'h20);
    chk("after_idle_data", dout, 32'h12345678);
`ifdef ECC_SCRUB_EN
    chk("after_idle_corr", err_corr, 0);
`else
    chk("after_idle_corr", err_corr, 1);
`endif
    cyc();
    wr(32'h20, 32'h12345678, 4'hF, 39'h1 << 0);
    rd(32'h20);
    chk("pre_rst_corr", err_corr, 1);
    rst = 1;
    #1;
    chk("mid_rst_corr", err_corr, 0);
    chk("mid_rst_data", dout, 0);
    chk("mid_rst_corr_cnt", corr_cnt, 0);
    chk("mid_rst_err_addr", err_addr, 0);
    cyc();
    rst = 0;
    cyc();
    rd(32'h10);
    chk("post_rst_data", dout, 32'hDEADBEEF);
    chk("post_rst_corr", err_corr, 0);
    cyc(); cyc();
    mc = 0; mu = 0; mea = 0;
    for (int i = 0; i < 8; i++) begin
      m_data[i] = $urandom;
      m_flip[i] = 0;
      wr({20'h0, 10'(256 + i), 2'b00}, m_data[i], 4'hF, 0);
    end
    for (int t = 0; t < 120; t++) begin
      k = $urandom_range(0, 7);
      a = {$urandom_range(0, 32'hFFFFF), 10'(256 + k), 2'($urandom_range(0, 3))};
      if ($urandom_range(0, 1) == 1) begin
        d = $urandom;
        f = 0;
        pc = $urandom_range(0, 2);
        p1 = $urandom_range(0, 38);
        p2 = (p1 + 1 + $urandom_range(0, 37)) % 39;
        if (pc >= 1) f[p1] = 1'b1;
        if (pc == 2) f[p2] = 1'b1;
        b = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(0, 14)) : 4'hF;
        wr(a, d, b, f);
        chk("rnd_be_err", be_err, b != 4'hF);
        if (b == 4'hF) begin
          m_data[k] = d;
          m_flip[k] = f;
        end
      end else begin
        rd(a);
        pc = $countones(m_flip[k]);
        ed = (pc == 2) ? flip_data(m_data[k], m_flip[k]) : m_data[k];
        chk("rnd_data", dout, ed);
        chk("rnd_corr", err_corr, pc == 1);
        chk("rnd_uncorr", err_uncorr, pc == 2);
        if (pc == 1) begin
          mc = (mc == 15) ? 15 : mc + 1;
          mea = a;
`ifdef ECC_SCRUB_EN
          m_flip[k] = 0;
`endif
        end
        if (pc == 2) begin
          mu = (mu == 15) ? 15 : mu + 1;
          mea = a;
        end
      end
      cyc(); cyc();
      chk("rnd_corr_cnt", corr_cnt, mc);
      chk("rnd_uncorr_cnt", uncorr_cnt, mu);
      chk("rnd_err_addr", err_addr, mea);
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
